// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: register width,
// op encodings and FSM state encodings.
`ifndef MULT_DIV_UNIT_DEFS
`define MULT_DIV_UNIT_DEFS
`define REG_W 32
`endif

package mult_div_unit_pkg;

  localparam int REG_W = `REG_W;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_SIGN = 2'b10
  } mdState_e;

endpackage

// File: rtl/mult_div_unit_md_iter_core.sv
// Iteration datapath: magnitude registers, 2*W accumulator and step counter.
// Performs one shift-add (multiply) or one restoring step (divide) per iStep.
module md_iter_core #(
  parameter int W = 32
) (
  input  logic           iClk,
  input  logic           iReset,
  input  logic           iLoad,
  input  logic           iStep,
  input  logic           iIsDiv,
  input  logic [W-1:0]   iMagA,
  input  logic [W-1:0]   iMagB,
  output logic [2*W-1:0] oAcc,
  output logic           oLast
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] accR;
  logic [W-1:0]   magAR;
  logic [W-1:0]   magBR;
  logic [CW-1:0]  countR;

  logic [W:0]     mulSumS;
  logic [W:0]     trialS;
  logic [W:0]     diffS;
  logic           fitsS;
  logic [2*W-1:0] nextAccS;
  logic [W-1:0]   nextMagAS;
  logic [W-1:0]   nextMagBS;

  // Divide: remainder lives in the upper half, quotient bits shift into the lower half.
  assign mulSumS = {1'b0, accR[2*W-1:W]} + {1'b0, magAR};
  assign trialS  = {accR[2*W-1:W], magAR[W-1]};
  assign diffS   = trialS - {1'b0, magBR};
  assign fitsS   = ~diffS[W];

  // One iteration of the selected algorithm.
  always_comb begin
    nextAccS  = accR;
    nextMagAS = magAR;
    nextMagBS = magBR;
    if (iIsDiv) begin
      nextAccS  = {(fitsS ? diffS[W-1:0] : trialS[W-1:0]), accR[W-2:0], fitsS};
      nextMagAS = {magAR[W-2:0], 1'b0};
    end else begin
      nextAccS  = magBR[0] ? {mulSumS, accR[W-1:1]} : {1'b0, accR[2*W-1:1]};
      nextMagBS = {1'b0, magBR[W-1:1]};
    end
  end

  // Datapath registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      accR   <= {(2*W){1'b0}};
      magAR  <= {W{1'b0}};
      magBR  <= {W{1'b0}};
      countR <= {CW{1'b0}};
    end else if (iLoad) begin
      accR   <= {(2*W){1'b0}};
      magAR  <= iMagA;
      magBR  <= iMagB;
      countR <= CW'(W);
    end else if (iStep) begin
      accR   <= nextAccS;
      magAR  <= nextMagAS;
      magBR  <= nextMagBS;
      countR <= countR - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      accR   <= accR;
      magAR  <= magAR;
      magBR  <= magBR;
      countR <= countR;
    end
  end

  assign oAcc  = accR;
  assign oLast = (countR == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling, HI/LO registers and
// the start/busy/done handshake around the md_iter_core datapath.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = REG_W
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iStart,
  input  logic [1:0]            iOp,
  input  logic [DATA_WIDTH-1:0] iOpA,
  input  logic [DATA_WIDTH-1:0] iOpB,
  input  logic                  iWrHi,
  input  logic                  iWrLo,
  input  logic [DATA_WIDTH-1:0] iWrData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oDivZero,
  output logic [DATA_WIDTH-1:0] oHi,
  output logic [DATA_WIDTH-1:0] oLo
);

  localparam int W = DATA_WIDTH;

  mdState_e       stateR, nextStateS;
  logic           isDivR, negResR, negRemR, divZeroR;
  logic [W-1:0]   opARawR, hiR, loR;
  logic           doneR, divZeroPulseR;

  logic           startS, startSignedS, startDivS, lastS;
  logic [W-1:0]   magAS, magBS, resHiS, resLoS;
  logic [2*W-1:0] accS, prodS;

  assign startS       = (stateR == MD_IDLE) && iStart;
  assign startSignedS = (iOp == MD_MULT) || (iOp == MD_DIV);
  assign startDivS    = (iOp == MD_DIV) || (iOp == MD_DIVU);
  assign magAS        = (startSignedS && iOpA[W-1]) ? -iOpA : iOpA;
  assign magBS        = (startSignedS && iOpB[W-1]) ? -iOpB : iOpB;

  md_iter_core #(.W(W)) uCore (
    .iClk   (iClk),
    .iReset (iReset),
    .iLoad  (startS),
    .iStep  (stateR == MD_CALC),
    .iIsDiv (isDivR),
    .iMagA  (magAS),
    .iMagB  (magBS),
    .oAcc   (accS),
    .oLast  (lastS)
  );

  // State register.
  always_ff @(posedge iClk) begin
    if (iReset) stateR <= MD_IDLE;
    else        stateR <= nextStateS;
  end

  // Next-state logic.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      MD_IDLE: if (iStart) nextStateS = MD_CALC; else nextStateS = MD_IDLE;
      MD_CALC: if (lastS)  nextStateS = MD_SIGN; else nextStateS = MD_CALC;
      MD_SIGN: nextStateS = MD_IDLE;
      default: nextStateS = MD_IDLE;
    endcase
  end

  // Final sign fix-up; divide-by-zero overrides the iterated result.
  always_comb begin
    prodS  = negResR ? -accS : accS;
    resHiS = prodS[2*W-1:W];
    resLoS = prodS[W-1:0];
    if (divZeroR) begin
      resHiS = opARawR;
      resLoS = {W{1'b1}};
    end else if (isDivR) begin
      resHiS = negRemR ? -accS[2*W-1:W] : accS[2*W-1:W];
      resLoS = negResR ? -accS[W-1:0]   : accS[W-1:0];
    end else begin
      resHiS = prodS[2*W-1:W];
      resLoS = prodS[W-1:0];
    end
  end

  // Operation capture, HI/LO registers and completion pulses.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      isDivR        <= 1'b0;
      negResR       <= 1'b0;
      negRemR       <= 1'b0;
      divZeroR      <= 1'b0;
      opARawR       <= {W{1'b0}};
      hiR           <= {W{1'b0}};
      loR           <= {W{1'b0}};
      doneR         <= 1'b0;
      divZeroPulseR <= 1'b0;
    end else begin
      doneR         <= (stateR == MD_SIGN);
      divZeroPulseR <= (stateR == MD_SIGN) && divZeroR;
      if (startS) begin
        isDivR   <= startDivS;
        negResR  <= startSignedS && (iOpA[W-1] ^ iOpB[W-1]);
        negRemR  <= startSignedS && startDivS && iOpA[W-1];
        divZeroR <= startDivS && (iOpB == {W{1'b0}});
        opARawR  <= iOpA;
      end
      if (stateR == MD_SIGN) begin
        hiR <= resHiS;
        loR <= resLoS;
      end else if (stateR == MD_IDLE && !iStart) begin
        if (iWrHi) hiR <= iWrData;
        if (iWrLo) loR <= iWrData;
      end
    end
  end

  assign oBusy    = (stateR != MD_IDLE);
  assign oDone    = doneR;
  assign oDivZero = divZeroPulseR;
  assign oHi      = hiR;
  assign oLo      = loR;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage, holding the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake, and accepts MTHI/MTLO writes. oHi/oLo feed the writeback-select mux that serves MFHI/MFLO. The hazard logic stalls on oBusy.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; must equal `REG_W.
- iClk  in  1  clock; all state changes on the rising edge.
- iReset  in  1  reset, synchronous and active-high.
- iStart  in  1  launch request; sampled only in IDLE.
- iOp  in  2  op select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- iOpA  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- iOpB  in  DATA_WIDTH  rt operand (multiplier / divisor).
- iWrHi  in  1  MTHI write strobe.
- iWrLo  in  1  MTLO write strobe.
- iWrData  in  DATA_WIDTH  MTHI/MTLO data.
- oBusy  out  1  operation in progress.
- oDone  out  1  one-cycle completion pulse.
- oDivZero  out  1  one-cycle pulse coincident with oDone when a divide had iOpB==0.
- oHi  out  DATA_WIDTH  architectural HI.
- oLo  out  DATA_WIDTH  architectural LO.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE with iStart: capture the op, the operand magnitudes (abs value for MULT/DIV, raw for MULTU/DIVU), the result-sign flags, and the divide-by-zero flag. Clear the 2*DATA_WIDTH accumulator, load the counter with DATA_WIDTH, and go to CALC.
- CALC: one iteration per cycle. The counter decrements and SIGN is entered after DATA_WIDTH iterations.
  - Multiply: shift-add, 1 multiplier bit per cycle, into the 2*DATA_WIDTH accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- SIGN: one cycle, then IDLE.
  - Multiply: negate the 64-bit product if the operand signs differ (MULT only). HI gets the upper half, LO the lower half.
  - Divide: LO gets the quotient, negated if the signs differ. HI gets the remainder, negated if the dividend is negative (DIV only).
  - Register the oDone pulse.
- Divide by zero: the iterations still run, giving the same latency. The result is forced to HI = iOpA as captured and LO = all ones. oDivZero pulses with oDone.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0, no flag.
- MTHI/MTLO: apply only in IDLE with iStart low, and update on the next edge. iWrHi and iWrLo may both be high in the same cycle.
- Ignored inputs:
  - iStart outside IDLE.
  - iWrHi/iWrLo outside IDLE.
  - iWrHi/iWrLo in IDLE when iStart is high (the start wins).
- oBusy = (state != IDLE).
- oHi/oLo change only in the SIGN cycle, on an MTHI/MTLO write, or on reset.

## Timing
- Reset values: state IDLE, oBusy 0, oDone 0, oDivZero 0, oHi 0, oLo 0, counter 0.
- Reset mid-operation: on the next edge everything returns to the reset values. No oDone is produced for the aborted operation.
- iStart sampled at edge E0. oBusy is high for 33 cycles (32 CALC + 1 SIGN) after E0.
- The result lands at edge E33. In the following cycle (34 cycles after the iStart cycle):
  - oDone = 1 and oBusy = 0;
  - oHi/oLo show the new values.
- A new iStart is accepted in that same oDone cycle, giving back-to-back throughput of one operation per 34 cycles.
- MTHI/MTLO latency: 1 cycle.

## Structure
- Shared include, alongside `REG_W:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - FSM state encodings MD_IDLE, MD_CALC, MD_SIGN.
- One sub-module, md_iter_core. It holds the 2*DATA_WIDTH accumulator, the magnitude registers and the iteration counter, and performs one shift-add or restore step per enable.
- The top level holds the FSM, sign handling, HI/LO registers and the handshake.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. oDone exactly 34 cycles after iStart; oBusy high for 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, oDivZero=0.
- DIV 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF. oDivZero pulses with oDone at cycle 34.
- iWrHi=1, iWrData=0xA5A5A5A5 in IDLE -> oHi=0xA5A5A5A5 next cycle. The same write plus a second iStart while busy -> both ignored, and the original result is delivered intact.
- iReset asserted in the 10th CALC cycle -> next cycle: oBusy=0, oHi=oLo=0, and no oDone within 40 cycles. A subsequent MULTU 3×5 gives LO=15, HI=0.
